answer_gen: RTL and testbench

Parametrised pseudo-random answer generator for the number-guessing game. A free-running 32-bit linear congruential generator (LCG) feeds a rejection-sampling state machine. On each `change_answer` request, the state machine assembles DIGITS mutually distinct digits in the range 1..MAX_VAL, then publishes them with a one-cycle `write_enable` strobe. It sits between the game controller, which issues `change_answer`, and the answer register/comparator, which consumes `answer` on `write_enable`.

---
 rtl/answer_gen.sv | 160 ++++++++++++++++
 tb/tb_answer_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/answer_gen.sv
// answer_gen
// ----------
// Pseudo-random answer generator for the number-guessing game. A free-running
// 32-bit LCG supplies candidate digits. A rejection-sampling FSM collects
// DIGITS mutually distinct digits in 1..MAX_VAL and publishes them with a
// one-cycle write strobe.
//
// Ports
//   clk_i            single clock, all logic on the rising edge
//   rst_i            synchronous active-high reset, highest priority
//   change_answer_i  request level; a rising edge starts a generation
//   seed_load_i      load seed_in_i into the LCG state on the next edge
//   seed_in_i        seed value
//   rand_o           current LCG state (straight from the register)
//   answer_o         published answer, digit 0 in the LSBs
//   write_enable_o   one-cycle strobe marking a new answer_o
//   busy_o           high while a generation is in progress
//   dbg_state_o      current FSM state (0 IDLE, 1 GEN, 2 DONE)
//
// Handshake: a request is accepted only in IDLE. Once accepted, busy_o stays
// high until the edge on which write_enable_o rises. Requests seen while busy
// are dropped and never queued.

module answer_gen #(
    parameter logic [31:0] A       = 32'd1103515245,
    parameter logic [31:0] C       = 32'd12345,
    parameter logic [31:0] SEED    = 32'd1,
    parameter int          DIGITS  = 3,
    parameter int          DIGIT_W = 4,
    parameter int          MAX_VAL = 9
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        change_answer_i,
    input  logic                        seed_load_i,
    input  logic [31:0]                 seed_in_i,
    output logic [31:0]                 rand_o,
    output logic [DIGITS*DIGIT_W-1:0]   answer_o,
    output logic                        write_enable_o,
    output logic                        busy_o,
    output logic [1:0]                  dbg_state_o
);

    // idx must be able to hold the value DIGITS itself
    localparam int IDX_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                           state_q, state_d;
    logic [31:0]                      rand_q, rand_d;
    logic                             chg_q;
    logic                             req;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [DIGITS-1:0][DIGIT_W-1:0]   slots_q, slots_d;
    logic [DIGITS*DIGIT_W-1:0]        answer_q, answer_d;
    logic                             we_q, we_d;
    logic                             busy_q, busy_d;
    logic [14:0]                      rmod;
    logic [DIGIT_W-1:0]               cand;
    logic                             dup;

    // LCG next state; reset is applied in the register block
    always_comb begin
        rand_d = A * rand_q + C;
        if (seed_load_i) begin
            rand_d = seed_in_i;
        end
    end

    // Bits 30:16 avoid the short-period low bits of a power-of-two LCG
    assign rmod = rand_q[30:16] % 15'(MAX_VAL);
    assign cand = DIGIT_W'(rmod) + DIGIT_W'(1);

    assign req = change_answer_i & ~chg_q;

    // Candidate is a duplicate if it matches any slot already accepted
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((IDX_W'(i) < idx_q) && (slots_q[i] == cand)) begin
                dup = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        slots_d  = slots_q;
        answer_d = answer_q;
        we_d     = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_GEN;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_GEN: begin
                if (!dup) begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            slots_d[i] = cand;
                        end
                    end
                    idx_d = idx_q + IDX_W'(1);
                    // Last slot filled this cycle: publish on the next edge
                    if (idx_q == IDX_W'(DIGITS - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                answer_d = slots_q;
                we_d     = 1'b1;
                busy_d   = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            rand_q   <= SEED;
            chg_q    <= 1'b0;
            idx_q    <= '0;
            slots_q  <= '0;
            answer_q <= '0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rand_q   <= rand_d;
            // Tracks the level even while busy so a held request cannot retrigger
            chg_q    <= change_answer_i;
            idx_q    <= idx_d;
            slots_q  <= slots_d;
            answer_q <= answer_d;
            we_q     <= we_d;
            busy_q   <= busy_d;
        end
    end

    assign rand_o         = rand_q;
    assign answer_o       = answer_q;
    assign write_enable_o = we_q;
    assign busy_o         = busy_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_answer_gen.sv
// Directed testbench for answer_gen: a default instance (3 digits of 1..9)
// and a 4-of-4 instance. Inputs change on the falling edge, outputs are
// sampled on the falling edge.

module tb_answer_gen;

    localparam logic [31:0] LA    = 32'd1103515245;
    localparam logic [31:0] LC    = 32'd12345;
    localparam logic [31:0] LSEED = 32'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, change, seed_load, change2, seed_load2;
    logic [31:0] seed_in, seed_in2;
    logic [31:0] rand1, rand2;
    logic [11:0] ans1, ans2;
    logic        we1, we2, busy1, busy2;
    logic [1:0]  st1, st2;

    answer_gen dut (
        .clk_i(clk), .rst_i(rst), .change_answer_i(change), .seed_load_i(seed_load),
        .seed_in_i(seed_in), .rand_o(rand1), .answer_o(ans1), .write_enable_o(we1),
        .busy_o(busy1), .dbg_state_o(st1)
    );

    answer_gen #(.DIGITS(4), .DIGIT_W(3), .MAX_VAL(4)) dut2 (
        .clk_i(clk), .rst_i(rst), .change_answer_i(change2), .seed_load_i(seed_load2),
        .seed_in_i(seed_in2), .rand_o(rand2), .answer_o(ans2), .write_enable_o(we2),
        .busy_o(busy2), .dbg_state_o(st2)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          we_cnt = 0, we_cyc = 0, we2_cnt = 0, we2_cyc = 0;
    logic [31:0] m_rand = '0, m_rand2 = '0;

    function automatic logic [31:0] lcg(input logic [31:0] x);
        return x * LA + LC;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference generation: candidates are drawn from the LCG states that
    // follow r0 (the state present in the request cycle).
    task automatic gen_model(input logic [31:0] r0, input int nd, input int maxv,
                             input int dw, output logic [31:0] ans, output int ncand);
        logic [31:0] r;
        int          acc[16];
        int          n;
        int          c;
        bit          dup;
        r = r0; n = 0; ncand = 0; ans = '0;
        while (n < nd && ncand < 100000) begin
            r = lcg(r);
            ncand++;
            c = int'(r[30:16]) % maxv + 1;
            dup = 1'b0;
            for (int i = 0; i < n; i++) if (acc[i] == c) dup = 1'b1;
            if (!dup) begin
                acc[n] = c;
                ans = ans | (32'(c) << (dw * n));
                n++;
            end
        end
    endtask

    // One clock: update the LCG models from the inputs applied at this edge,
    // then sample outputs at the falling edge.
    task automatic tick();
        @(posedge clk);
        m_rand  = rst ? LSEED : (seed_load ? seed_in : lcg(m_rand));
        m_rand2 = rst ? LSEED : lcg(m_rand2);
        @(negedge clk);
        cyc++;
        if (we1) begin we_cnt++; we_cyc = cyc; end
        if (we2) begin we2_cnt++; we2_cyc = cyc; end
        check("rand_track", rand1, m_rand);
        check("rand2_track", rand2, m_rand2);
    endtask

    logic [31:0] exp_ans;
    int          ncand, req_cyc, n_hold;
    logic [3:0]  d0, d1, d2;
    logic [4:0]  mask;

    initial begin
        rst = 1'b1; change = 1'b0; seed_load = 1'b0; seed_in = '0;
        change2 = 1'b0; seed_load2 = 1'b0; seed_in2 = '0;

        // Reset held two cycles
        tick(); tick();
        check("reset_rand", rand1, 32'd1);
        check("reset_answer", ans1, 12'd0);
        check("reset_we", we1, 1'b0);
        check("reset_busy", busy1, 1'b0);
        check("reset_state", st1, 2'd0);
        rst = 1'b0;
        tick();
        check("rand_first_step", rand1, 32'd1103527590);

        // Seed load
        seed_in = 32'd0; seed_load = 1'b1;
        tick();
        check("seed_rand0", rand1, 32'd0);
        seed_load = 1'b0;
        tick();
        check("seed_rand1", rand1, 32'd12345);
        tick();
        check("seed_rand2", rand1, lcg(32'd12345));

        // Single generation with the request held high
        gen_model(m_rand, 3, 9, 4, exp_ans, ncand);
        we_cnt = 0; change = 1'b1;
        tick();
        req_cyc = cyc;
        check("busy_on_request", busy1, 1'b1);
        n_hold = (ncand + 3 > 20) ? ncand + 3 : 20;
        for (int i = 1; i < n_hold; i++) begin
            tick();
            check("gen_busy", busy1, (cyc < req_cyc + ncand + 1));
            check("gen_we", we1, (cyc == req_cyc + ncand + 1));
            check("gen_answer_stable", ans1,
                  (cyc >= req_cyc + ncand + 1) ? exp_ans[11:0] : 12'd0);
        end
        check("gen_we_count", we_cnt, 1);
        check("gen_latency", we_cyc - req_cyc, ncand + 1);
        check("gen_latency_min", (we_cyc - req_cyc) >= 4, 1'b1);
        check("gen_answer", ans1, exp_ans[11:0]);
        d0 = ans1[3:0]; d1 = ans1[7:4]; d2 = ans1[11:8];
        check("gen_digits_range", (d0 >= 1 && d0 <= 9 && d1 >= 1 && d1 <= 9 &&
                                   d2 >= 1 && d2 <= 9), 1'b1);
        check("gen_digits_distinct", (d0 != d1 && d0 != d2 && d1 != d2), 1'b1);
        change = 1'b0;
        tick();

        // Second rising edge while busy is ignored
        gen_model(m_rand, 3, 9, 4, exp_ans, ncand);
        we_cnt = 0; change = 1'b1;
        tick();
        req_cyc = cyc;
        change = 1'b0;
        tick();
        change = 1'b1;
        tick();
        check("ign_busy_during_toggle", busy1, 1'b1);
        change = 1'b0;
        for (int i = 0; i < ncand + 6; i++) tick();
        check("ign_we_count", we_cnt, 1);
        check("ign_latency", we_cyc - req_cyc, ncand + 1);
        check("ign_answer", ans1, exp_ans[11:0]);
        check("ign_busy_after", busy1, 1'b0);

        // Reset two cycles after a request
        we_cnt = 0; change = 1'b1;
        tick();
        tick();
        rst = 1'b1; change = 1'b0;
        tick();
        check("mid_rst_busy", busy1, 1'b0);
        check("mid_rst_we", we1, 1'b0);
        check("mid_rst_answer", ans1, 12'd0);
        check("mid_rst_state", st1, 2'd0);
        check("mid_rst_rand", rand1, 32'd1);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("mid_rst_no_we", we_cnt, 0);
        check("mid_rst_idle", busy1, 1'b0);

        // 4-of-4 sweep on the second instance
        for (int k = 0; k < 200; k++) begin
            gen_model(m_rand2, 4, 4, 3, exp_ans, ncand);
            we2_cnt = 0; change2 = 1'b1;
            tick();
            req_cyc = cyc;
            change2 = 1'b0;
            for (int i = 0; i < ncand + 3; i++) tick();
            check("sweep_we_count", we2_cnt, 1);
            check("sweep_latency", we2_cyc - req_cyc, ncand + 1);
            check("sweep_answer", ans2, exp_ans[11:0]);
            mask = '0;
            for (int i = 0; i < 4; i++) mask = mask | (5'd1 << ans2[3*i +: 3]);
            check("sweep_permutation", mask, 5'b11110);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
